id_ex_stage: RTL and testbench

- ID/EX pipeline register of the five-stage MIPS core, directly downstream of the instruction decoder.
- Captures the decoder's muxctrl/memctrl/aluctrl bundle plus operands and register addresses each cycle.
- Detects load-use hazards and requests an upstream stall.
- Inserts bubbles on hazard or flush; honours a hold from the EX/MEM side.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 18 +
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline widths, memctrl bit indices, ALU and forwarding codes
// Optional feature macro used by importers: ID_EX_FWD_EN
package mips_pkg;

  localparam int MUXCTRL_W = 7;
  localparam int MEMCTRL_W = 3;
  localparam int ALUCTRL_W = 5;

  localparam int MEM_REGWR = 0;
  localparam int MEM_WR    = 1;
  localparam int MEM_RD    = 2;

  localparam logic [ALUCTRL_W-1:0] ALU_NOOP = 5'b01101;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  // EX/MEM producer is younger, so it wins over the MEM/WB producer.
  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between EX load and ID sources
// Optional feature macro in this slice: ID_EX_FWD_EN (not used here)
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hz
);

  // $zero is never a real producer, so it can never create a hazard.
  assign hz = ex_valid & ex_mem_rd & (ex_rt != '0) &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, flush/hold and bubble insertion
// Optional feature macro: ID_EX_FWD_EN adds forwarding-select capture (mem_wr_i/mem_dst_i in, ex_fwd_a_o/ex_fwd_b_o out)
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MUXCTRL_W-1:0] id_muxctrl_i,
  input  logic [MEMCTRL_W-1:0] id_memctrl_i,
  input  logic [ALUCTRL_W-1:0] id_aluctrl_i,
  input  logic [REG_AW-1:0]    id_rs_i,
  input  logic [REG_AW-1:0]    id_rt_i,
  input  logic [REG_AW-1:0]    id_rd_i,
  input  logic [4:0]           id_shamt_i,
  input  logic [DATA_W-1:0]    id_imm_i,
  input  logic [DATA_W-1:0]    id_rd1_i,
  input  logic [DATA_W-1:0]    id_rd2_i,
  input  logic [DATA_W-1:0]    id_pc4_i,
  input  logic                 flush_i,
  input  logic                 ex_hold_i,
`ifdef ID_EX_FWD_EN
  input  logic                 mem_wr_i,
  input  logic [REG_AW-1:0]    mem_dst_i,
  output logic [1:0]           ex_fwd_a_o,
  output logic [1:0]           ex_fwd_b_o,
`endif
  output logic                 stall_o,
  output logic [MUXCTRL_W-1:0] ex_muxctrl_o,
  output logic [MEMCTRL_W-1:0] ex_memctrl_o,
  output logic [ALUCTRL_W-1:0] ex_aluctrl_o,
  output logic [REG_AW-1:0]    ex_rs_o,
  output logic [REG_AW-1:0]    ex_rt_o,
  output logic [REG_AW-1:0]    ex_dst_o,
  output logic [4:0]           ex_shamt_o,
  output logic [DATA_W-1:0]    ex_imm_o,
  output logic [DATA_W-1:0]    ex_rd1_o,
  output logic [DATA_W-1:0]    ex_rd2_o,
  output logic [DATA_W-1:0]    ex_pc4_o,
  output logic                 ex_valid_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic hz;
  logic pending;
  logic flush_now;
  logic load_bubble;
  logic [REG_AW-1:0] dst_next;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid  (ex_valid_o),
    .ex_mem_rd (ex_memctrl_o[MEM_RD]),
    .ex_rt     (ex_rt_o),
    .id_rs     (id_rs_i),
    .id_rt     (id_rt_i),
    .hz        (hz)
  );

  assign stall_o     = hz | ex_hold_i;
  assign flush_now   = flush_i | pending;
  assign load_bubble = flush_now | hz;
  assign dst_next    = id_memctrl_i[MEM_RD] ? id_rt_i : id_rd_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      stall_cnt_o <= '0;
    end else if (ex_hold_i) begin
      // A flush seen while frozen must not be lost; apply it once the hold drops.
      if (flush_i) pending <= 1'b1;
    end else begin
      pending <= 1'b0;
      if (!flush_now && hz && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (!ex_hold_i && load_bubble)) begin
      ex_muxctrl_o <= '0;
      ex_memctrl_o <= '0;
      ex_aluctrl_o <= ALU_NOOP;
      ex_rs_o      <= '0;
      ex_rt_o      <= '0;
      ex_dst_o     <= '0;
      ex_shamt_o   <= '0;
      ex_imm_o     <= '0;
      ex_rd1_o     <= '0;
      ex_rd2_o     <= '0;
      ex_pc4_o     <= '0;
      ex_valid_o   <= 1'b0;
    end else if (!ex_hold_i) begin
      ex_muxctrl_o <= id_muxctrl_i;
      ex_memctrl_o <= id_memctrl_i;
      ex_aluctrl_o <= id_aluctrl_i;
      ex_rs_o      <= id_rs_i;
      ex_rt_o      <= id_rt_i;
      ex_dst_o     <= dst_next;
      ex_shamt_o   <= id_shamt_i;
      ex_imm_o     <= id_imm_i;
      ex_rd1_o     <= id_rd1_i;
      ex_rd2_o     <= id_rd2_i;
      ex_pc4_o     <= id_pc4_i;
      ex_valid_o   <= 1'b1;
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_sel_t fwd_a_next;
  fwd_sel_t fwd_b_next;
  logic     ex_writes;

  // The instruction now in EX moves to MEM next cycle; the one in MEM moves to WB.
  assign ex_writes  = ex_valid_o & ex_memctrl_o[MEM_REGWR];
  assign fwd_a_next = fwd_pick(ex_writes & (ex_dst_o == id_rs_i) & (id_rs_i != '0),
                               mem_wr_i & (mem_dst_i == id_rs_i) & (id_rs_i != '0));
  assign fwd_b_next = fwd_pick(ex_writes & (ex_dst_o == id_rt_i) & (id_rt_i != '0),
                               mem_wr_i & (mem_dst_i == id_rt_i) & (id_rt_i != '0));

  always_ff @(posedge clk) begin
    if (reset || (!ex_hold_i && load_bubble)) begin
      ex_fwd_a_o <= FWD_NONE;
      ex_fwd_b_o <= FWD_NONE;
    end else if (!ex_hold_i) begin
      ex_fwd_a_o <= fwd_a_next;
      ex_fwd_b_o <= fwd_b_next;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized self-checking bench for id_ex_stage against a behavioural model
// Optional feature macro: ID_EX_FWD_EN (forwarding outputs checked when defined)
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] id_mux;
  logic [2:0] id_mem;
  logic [4:0] id_alu, id_shamt;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_imm, id_rd1, id_rd2, id_pc4;
  logic flush, hold, stall;
  logic [6:0] ex_mux;
  logic [2:0] ex_mem;
  logic [4:0] ex_alu, ex_shamt;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst;
  logic [DATA_W-1:0] ex_imm, ex_rd1, ex_rd2, ex_pc4;
  logic ex_valid;
  logic [CNT_W-1:0] stall_cnt;
`ifdef ID_EX_FWD_EN
  logic mem_wr;
  logic [REG_AW-1:0] mem_dst;
  logic [1:0] fwd_a, fwd_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_muxctrl_i(id_mux), .id_memctrl_i(id_mem), .id_aluctrl_i(id_alu),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_shamt_i(id_shamt),
    .id_imm_i(id_imm), .id_rd1_i(id_rd1), .id_rd2_i(id_rd2), .id_pc4_i(id_pc4),
    .flush_i(flush), .ex_hold_i(hold),
`ifdef ID_EX_FWD_EN
    .mem_wr_i(mem_wr), .mem_dst_i(mem_dst), .ex_fwd_a_o(fwd_a), .ex_fwd_b_o(fwd_b),
`endif
    .stall_o(stall),
    .ex_muxctrl_o(ex_mux), .ex_memctrl_o(ex_mem), .ex_aluctrl_o(ex_alu),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_dst_o(ex_dst), .ex_shamt_o(ex_shamt),
    .ex_imm_o(ex_imm), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2), .ex_pc4_o(ex_pc4),
    .ex_valid_o(ex_valid), .stall_cnt_o(stall_cnt)
  );

  // Model of what the EX register should hold: one record, plus pending flag and counter.
  typedef struct {
    logic valid;
    logic [6:0] mux;
    logic [2:0] mem;
    logic [4:0] alu, shamt;
    logic [REG_AW-1:0] rs, rt, dst;
    logic [DATA_W-1:0] imm, rd1, rd2, pc4;
    logic [1:0] fa, fb;
  } ex_rec_t;

  ex_rec_t m;
  logic m_pend;
  int   m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_rec_t bubble();
    ex_rec_t b;
    b = '{valid: 1'b0, mux: '0, mem: '0, alu: ALU_NOOP, shamt: '0, rs: '0, rt: '0,
          dst: '0, imm: '0, rd1: '0, rd2: '0, pc4: '0, fa: 2'b00, fb: 2'b00};
    return b;
  endfunction

  function automatic logic model_hz();
    return m.valid && m.mem[2] && m.rt != 0 && (m.rt == id_rs || m.rt == id_rt);
  endfunction

  function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] s);
`ifdef ID_EX_FWD_EN
    if (s == 0) return 2'b00;
    if (m.valid && m.mem[0] && m.dst == s) return 2'b01;
    if (mem_wr && mem_dst == s) return 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic model_edge();
    ex_rec_t c;
    logic hzv;
    hzv = model_hz();
    if (reset) begin
      m = bubble(); m_pend = 1'b0; m_cnt = 0;
    end else if (hold) begin
      if (flush) m_pend = 1'b1;
    end else if (flush || m_pend) begin
      m = bubble(); m_pend = 1'b0;
    end else if (hzv) begin
      m = bubble();
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else begin
      c.valid = 1'b1; c.mux = id_mux; c.mem = id_mem; c.alu = id_alu; c.shamt = id_shamt;
      c.rs = id_rs; c.rt = id_rt; c.dst = id_mem[2] ? id_rt : id_rd;
      c.imm = id_imm; c.rd1 = id_rd1; c.rd2 = id_rd2; c.pc4 = id_pc4;
      c.fa = model_fwd(id_rs); c.fb = model_fwd(id_rt);
      m = c;
    end
  endtask

  task automatic check_regs();
    check("valid", 64'(ex_valid), 64'(m.valid));
    check("ctrl", {49'd0, ex_mux, ex_mem, ex_alu}, {49'd0, m.mux, m.mem, m.alu});
    check("regs", {44'd0, ex_rs, ex_rt, ex_dst, ex_shamt}, {44'd0, m.rs, m.rt, m.dst, m.shamt});
    check("imm_pc4", {ex_imm, ex_pc4}, {m.imm, m.pc4});
    check("rd1_rd2", {ex_rd1, ex_rd2}, {m.rd1, m.rd2});
    check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`ifdef ID_EX_FWD_EN
    check("fwd", {60'd0, fwd_a, fwd_b}, {60'd0, m.fa, m.fb});
`endif
  endtask

  // Inputs are already applied; check the combinational stall, clock once, check registers.
  task automatic cyc();
    #2;
    if (!reset) check("stall", 64'(stall), 64'(model_hz() | hold));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic set_id(input logic [2:0] mem, input logic [4:0] alu,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_mem = mem; id_alu = alu; id_rs = rs; id_rt = rt; id_rd = rd;
    id_mux = 7'($urandom); id_shamt = 5'($urandom);
    id_imm = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_pc4 = $urandom;
  endtask

  initial begin
    m = bubble(); m_pend = 1'b0; m_cnt = 0;
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
`ifdef ID_EX_FWD_EN
    mem_wr = 1'b0; mem_dst = '0;
`endif
    set_id(3'b000, 5'd0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    cyc(); cyc();
    check("reset_alu", 64'(ex_alu), 64'(5'b01101));
    reset = 1'b0;

    // ADD r3
    set_id(3'b001, 5'b00010, 5'd1, 5'd2, 5'd3); cyc();
    check("add_dst", 64'(ex_dst), 64'd3);
    check("add_valid", 64'(ex_valid), 64'd1);
    // LW r5 then dependent ADD: one bubble, then capture
    set_id(3'b101, 5'b00000, 5'd1, 5'd5, 5'd0); cyc();
    set_id(3'b001, 5'b00010, 5'd5, 5'd2, 5'd6);
    #1 check("lu_stall", 64'(stall), 64'd1);
    cyc();
    check("lu_bubble", {59'd0, ex_mem, ex_alu}, {59'd0, 3'b000, 5'b01101});
    check("lu_cnt", 64'(stall_cnt), 64'd1);
    cyc();
    check("lu_resume", 64'(ex_dst), 64'd6);
    // LW r0 then ADD rs=0: no stall
    set_id(3'b101, 5'b00000, 5'd1, 5'd0, 5'd0); cyc();
    set_id(3'b001, 5'b00010, 5'd0, 5'd0, 5'd4); cyc();
    check("r0_nostall", 64'(ex_valid), 64'd1);
    // flush beats a hazard
    set_id(3'b101, 5'b00000, 5'd1, 5'd7, 5'd0); cyc();
    set_id(3'b001, 5'b00010, 5'd7, 5'd7, 5'd8); flush = 1'b1; cyc(); flush = 1'b0;
    check("flush_cnt", 64'(stall_cnt), 64'd1);
    // hold 3 cycles, flush pulse in the second
    set_id(3'b001, 5'b00010, 5'd1, 5'd2, 5'd9); cyc();
    hold = 1'b1;
    set_id(3'b001, 5'b00011, 5'd2, 5'd3, 5'd10); cyc();
    flush = 1'b1; cyc(); flush = 1'b0; cyc();
    check("hold_frozen", 64'(ex_dst), 64'd9);
    hold = 1'b0; cyc();
    check("hold_bubble", 64'(ex_valid), 64'd0);
    cyc();
    check("hold_resume", 64'(ex_dst), 64'd10);
`ifdef ID_EX_FWD_EN
    set_id(3'b001, 5'b00010, 5'd1, 5'd2, 5'd7); cyc();
    set_id(3'b001, 5'b00010, 5'd7, 5'd9, 5'd11); mem_wr = 1'b1; mem_dst = 5'd9; cyc();
    check("fwd_ab", {60'd0, fwd_a, fwd_b}, {60'd0, 2'b01, 2'b10});
`endif

    // Random traffic on a small register set so hazards, forwarding and saturation occur.
    for (int i = 0; i < 3000; i++) begin
      set_id(3'($urandom), 5'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      reset = ($urandom_range(0, 199) == 0);
`ifdef ID_EX_FWD_EN
      mem_wr = 1'($urandom); mem_dst = 5'($urandom_range(0, 3));
`endif
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
